// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, record type and helper for the pipeline hazard controller.
// Tuse/Tnew encodings, forwarding-select codes and the return-address register.
package hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [1:0] FWD_GRF = 2'b00;
  localparam logic [1:0] FWD_E   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_W   = 2'b11;

  localparam logic [4:0] REG_RA = 5'd31;

  // A destination of 0 marks an empty slot.
  typedef struct packed {
    logic [4:0] dest;
    logic [1:0] tnew;
  } dest_rec_t;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_rec_gen.sv
// Combinational decode of D-stage class flags into source-use info and the
// destination record the instruction will carry into E.
import hazard_ctrl_pkg::*;

module hazard_rec_gen (
  input  logic       d_cal_r,
  input  logic       d_cal_i,
  input  logic       d_lui,
  input  logic       d_load,
  input  logic       d_store,
  input  logic       d_branch,
  input  logic       d_jal,
  input  logic       d_jr,
  input  logic       d_jalr,
  input  logic       d_shift,
  input  logic       d_md_start,
  input  logic       d_md_acc,
  input  logic       d_md_wr,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_rd,
  output logic       rs_use,
  output logic       rt_use,
  output logic [1:0] rs_tuse,
  output logic [1:0] rt_tuse,
  output logic [4:0] dest,
  output logic [1:0] tnew
);

  logic md_to,    // mthi/mtlo
        no_gpr;   // R-type MDU op with no GPR result

  assign md_to  = d_md_acc & ~d_md_wr;
  assign no_gpr = (d_md_start | d_md_acc) & ~d_md_wr;

  // Earliest consumer wins when several flags name the same field.
  always_comb begin
    rs_use  = 1'b0;
    rs_tuse = TUSE_2;
    if (d_branch || d_jr || d_jalr) begin
      rs_use  = 1'b1;
      rs_tuse = TUSE_0;
    end else if (d_cal_r || d_cal_i || d_load || d_store || md_to) begin
      rs_use  = 1'b1;
      rs_tuse = TUSE_1;
    end
  end

  always_comb begin
    rt_use  = 1'b0;
    rt_tuse = TUSE_2;
    if (d_branch) begin
      rt_use  = 1'b1;
      rt_tuse = TUSE_0;
    end else if (d_cal_r || d_shift) begin
      rt_use  = 1'b1;
      rt_tuse = TUSE_1;
    end else if (d_store) begin
      rt_use  = 1'b1;
      rt_tuse = TUSE_2;
    end
  end

  always_comb begin
    dest = 5'd0;
    tnew = TNEW_0;
    if (d_jal) begin
      dest = REG_RA;
      tnew = TNEW_0;
    end else if (d_jalr) begin
      dest = d_rd;
      tnew = TNEW_0;
    end else if (d_load) begin
      dest = d_rt;
      tnew = TNEW_2;
    end else if (d_cal_i || d_lui) begin
      dest = d_rt;
      tnew = TNEW_1;
    end else if ((d_cal_r && !no_gpr) || d_shift || d_md_wr) begin
      dest = d_rd;
      tnew = TNEW_1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble and D-stage forwarding controller with a shadow E/M/W record
// pipeline. Define MDU_STALL_EN to add the multiply/divide busy interlock.
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_cal_r,
  input  logic       d_cal_i,
  input  logic       d_lui,
  input  logic       d_load,
  input  logic       d_store,
  input  logic       d_branch,
  input  logic       d_jal,
  input  logic       d_jr,
  input  logic       d_jalr,
  input  logic       d_shift,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_acc,
  input  logic       d_md_wr,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_rd,
  output logic       stall,
  output logic       e_bubble,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic       md_busy
);

  logic       rs_use, rt_use;
  logic [1:0] rs_tuse, rt_tuse;
  dest_rec_t  d_rec;

  dest_rec_t  e_rec_reg, e_rec_next;
  dest_rec_t  m_rec_reg, m_rec_next;
  logic [4:0] w_dest_reg;
  logic       md_stall;

  hazard_rec_gen u_rec_gen (
    .d_cal_r    (d_cal_r),
    .d_cal_i    (d_cal_i),
    .d_lui      (d_lui),
    .d_load     (d_load),
    .d_store    (d_store),
    .d_branch   (d_branch),
    .d_jal      (d_jal),
    .d_jr       (d_jr),
    .d_jalr     (d_jalr),
    .d_shift    (d_shift),
    .d_md_start (d_md_start),
    .d_md_acc   (d_md_acc),
    .d_md_wr    (d_md_wr),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_rd       (d_rd),
    .rs_use     (rs_use),
    .rt_use     (rt_use),
    .rs_tuse    (rs_tuse),
    .rt_tuse    (rt_tuse),
    .dest       (d_rec.dest),
    .tnew       (d_rec.tnew)
  );

  // Per-source hazard check: index 0 is rs, index 1 is rt.
  logic [4:0] src       [2];
  logic       src_use   [2];
  logic [1:0] src_tuse  [2];
  logic       src_stall [2];
  logic [1:0] src_fwd   [2];

  assign src[0]      = d_rs;
  assign src[1]      = d_rt;
  assign src_use[0]  = rs_use;
  assign src_use[1]  = rt_use;
  assign src_tuse[0] = rs_tuse;
  assign src_tuse[1] = rt_tuse;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic nz, e_hit, m_hit, w_hit;
      assign nz    = (src[gi] != 5'd0);
      assign e_hit = nz && (e_rec_reg.dest == src[gi]);
      assign m_hit = nz && (m_rec_reg.dest == src[gi]);
      assign w_hit = nz && (w_dest_reg == src[gi]);

      assign src_stall[gi] = src_use[gi] &&
                             ((e_hit && (e_rec_reg.tnew > src_tuse[gi])) ||
                              (m_hit && (m_rec_reg.tnew > src_tuse[gi])));

      assign src_fwd[gi] = (e_hit && e_rec_reg.tnew == TNEW_0) ? FWD_E :
                           (m_hit && m_rec_reg.tnew == TNEW_0) ? FWD_M :
                           w_hit                               ? FWD_W :
                                                                 FWD_GRF;
    end
  endgenerate

  assign stall    = src_stall[0] | src_stall[1] | md_stall;
  assign e_bubble = stall;
  assign fwd_rs_d = src_fwd[0];
  assign fwd_rt_d = src_fwd[1];

  always_comb begin
    e_rec_next      = stall ? '0 : d_rec;
    m_rec_next.dest = e_rec_reg.dest;
    m_rec_next.tnew = sat_dec(e_rec_reg.tnew);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rec_reg  <= '0;
      m_rec_reg  <= '0;
      w_dest_reg <= 5'd0;
    end else begin
      e_rec_reg  <= e_rec_next;
      m_rec_reg  <= m_rec_next;
      w_dest_reg <= m_rec_reg.dest;
    end
  end

`ifdef MDU_STALL_EN
  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] md_cnt_reg, md_cnt_next;
  logic             e_md_reg, e_md_next;

  // A just-issued md op in E blocks followers even before the count is visible.
  assign md_stall = (d_md_start | d_md_acc) & ((md_cnt_reg != '0) | e_md_reg);
  assign md_busy  = (md_cnt_reg != '0);

  always_comb begin
    md_cnt_next = md_cnt_reg;
    e_md_next   = d_md_start & ~stall;
    if (d_md_start && !stall)
      md_cnt_next = d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (md_cnt_reg != '0)
      md_cnt_next = md_cnt_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_reg <= '0;
      e_md_reg   <= 1'b0;
    end else begin
      md_cnt_reg <= md_cnt_next;
      e_md_reg   <= e_md_next;
    end
  end
`else
  logic unused_md;
  assign unused_md = d_md_div ^ (MULT_CYCLES > DIV_CYCLES);
  assign md_stall  = 1'b0;
  assign md_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction pairs push expected
// controls into a queue; a negedge monitor pops and compares each cycle.
module tb_hazard_ctrl;

  localparam int K_NOP  = 0;
  localparam int K_ADDU = 1;
  localparam int K_ORI  = 2;
  localparam int K_LW   = 3;
  localparam int K_SW   = 4;
  localparam int K_BEQ  = 5;
  localparam int K_JAL  = 6;
  localparam int K_JR   = 7;
  localparam int K_MULT = 8;
  localparam int K_MFLO = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_cal_r, d_cal_i, d_lui, d_load, d_store, d_branch, d_jal;
  logic       d_jr, d_jalr, d_shift, d_md_start, d_md_div, d_md_acc, d_md_wr;
  logic [4:0] d_rs, d_rt, d_rd;
  logic       stall, e_bubble, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] frs;
    logic [1:0] frt;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_cal_r    (d_cal_r),
    .d_cal_i    (d_cal_i),
    .d_lui      (d_lui),
    .d_load     (d_load),
    .d_store    (d_store),
    .d_branch   (d_branch),
    .d_jal      (d_jal),
    .d_jr       (d_jr),
    .d_jalr     (d_jalr),
    .d_shift    (d_shift),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_acc   (d_md_acc),
    .d_md_wr    (d_md_wr),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_rd       (d_rd),
    .stall      (stall),
    .e_bubble   (e_bubble),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .md_busy    (md_busy)
  );

  task automatic set_instr(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd);
    {d_cal_r, d_cal_i, d_lui, d_load, d_store, d_branch, d_jal} = '0;
    {d_jr, d_jalr, d_shift, d_md_start, d_md_div, d_md_acc, d_md_wr} = '0;
    d_rs = rs;
    d_rt = rt;
    d_rd = rd;
    case (kind)
      K_ADDU: d_cal_r = 1'b1;
      K_ORI:  d_cal_i = 1'b1;
      K_LW:   d_load = 1'b1;
      K_SW:   d_store = 1'b1;
      K_BEQ:  d_branch = 1'b1;
      K_JAL:  d_jal = 1'b1;
      K_JR:   d_jr = 1'b1;
      K_MULT: begin d_cal_r = 1'b1; d_md_start = 1'b1; end
      K_MFLO: begin d_md_acc = 1'b1; d_md_wr = 1'b1; end
      default: ;
    endcase
  endtask

  // One D-stage cycle: drive the instruction and queue what the DUT must show.
  task automatic issue(input string name, input int kind, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic s,
                       input logic [1:0] frs, input logic [1:0] frt, input logic b);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_instr(kind, rs, rt, rd);
    e.name = name; e.stall = s; e.frs = frs; e.frt = frt; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_instr(K_NOP, 5'd0, 5'd0, 5'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %s: stall=%0b bubble=%0b frs=%02b frt=%02b busy=%0b (want %0b %02b %02b %0b)",
               e.name, stall, e_bubble, fwd_rs_d, fwd_rt_d, md_busy,
               e.stall, e.frs, e.frt, e.busy);
      total += 5;
      if (stall !== e.stall) begin
        bad++; $display("FAIL %s stall got=%0b want=%0b", e.name, stall, e.stall);
      end
      if (e_bubble !== e.stall) begin
        bad++; $display("FAIL %s e_bubble got=%0b want=%0b", e.name, e_bubble, e.stall);
      end
      if (fwd_rs_d !== e.frs) begin
        bad++; $display("FAIL %s fwd_rs_d got=%02b want=%02b", e.name, fwd_rs_d, e.frs);
      end
      if (fwd_rt_d !== e.frt) begin
        bad++; $display("FAIL %s fwd_rt_d got=%02b want=%02b", e.name, fwd_rt_d, e.frt);
      end
      if (md_busy !== e.busy) begin
        bad++; $display("FAIL %s md_busy got=%0b want=%0b", e.name, md_busy, e.busy);
      end
    end
  end

  initial begin
    set_instr(K_NOP, 5'd0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);

    // Post-reset idle state
    issue("rst_idle",   K_NOP,  5'd0, 5'd0, 5'd0, 0, 2'b00, 2'b00, 0);

    // lw $2 ; addu $3,$2,$4 : one stall, selects stay GRF
    pulse_reset();
    issue("lw_a",       K_LW,   5'd1, 5'd2, 5'd0, 0, 2'b00, 2'b00, 0);
    issue("addu_stl",   K_ADDU, 5'd2, 5'd4, 5'd3, 1, 2'b00, 2'b00, 0);
    issue("addu_go",    K_ADDU, 5'd2, 5'd4, 5'd3, 0, 2'b00, 2'b00, 0);

    // lw $2 ; beq $2,$0 : two stalls then W forward
    pulse_reset();
    issue("lw_b",       K_LW,   5'd1, 5'd2, 5'd0, 0, 2'b00, 2'b00, 0);
    issue("beq_stl1",   K_BEQ,  5'd2, 5'd0, 5'd0, 1, 2'b00, 2'b00, 0);
    issue("beq_stl2",   K_BEQ,  5'd2, 5'd0, 5'd0, 1, 2'b00, 2'b00, 0);
    issue("beq_fw_w",   K_BEQ,  5'd2, 5'd0, 5'd0, 0, 2'b11, 2'b00, 0);

    // ori $5 ; beq $5,$5 : one stall then M forward on both
    pulse_reset();
    issue("ori",        K_ORI,  5'd1, 5'd5, 5'd0, 0, 2'b00, 2'b00, 0);
    issue("beq5_stl",   K_BEQ,  5'd5, 5'd5, 5'd0, 1, 2'b00, 2'b00, 0);
    issue("beq5_fw_m",  K_BEQ,  5'd5, 5'd5, 5'd0, 0, 2'b10, 2'b10, 0);

    // jal ; jal ; jr $31 x3 : E, then M, then W priority
    pulse_reset();
    issue("jal1",       K_JAL,  5'd0, 5'd0, 5'd0, 0, 2'b00, 2'b00, 0);
    issue("jal2",       K_JAL,  5'd0, 5'd0, 5'd0, 0, 2'b00, 2'b00, 0);
    issue("jr_fw_e",    K_JR,   5'd31, 5'd0, 5'd0, 0, 2'b01, 2'b00, 0);
    issue("jr_fw_m",    K_JR,   5'd31, 5'd0, 5'd0, 0, 2'b10, 2'b00, 0);
    issue("jr_fw_w",    K_JR,   5'd31, 5'd0, 5'd0, 0, 2'b11, 2'b00, 0);

    // addu $0 ; beq $0,$0 : register zero never hazards
    pulse_reset();
    issue("addu_r0",    K_ADDU, 5'd1, 5'd1, 5'd0, 0, 2'b00, 2'b00, 0);
    issue("beq_r0",     K_BEQ,  5'd0, 5'd0, 5'd0, 0, 2'b00, 2'b00, 0);

    // lw $7 ; sw $7 : store data Tuse 2 does not stall
    pulse_reset();
    issue("lw_c",       K_LW,   5'd1, 5'd7, 5'd0, 0, 2'b00, 2'b00, 0);
    issue("sw_late",    K_SW,   5'd1, 5'd7, 5'd0, 0, 2'b00, 2'b00, 0);

    // Reset flushes a pending load hazard
    pulse_reset();
    issue("lw_d",       K_LW,   5'd1, 5'd2, 5'd0, 0, 2'b00, 2'b00, 0);
    pulse_reset();
    issue("addu_flush", K_ADDU, 5'd2, 5'd4, 5'd3, 0, 2'b00, 2'b00, 0);

    pulse_reset();
`ifdef MDU_STALL_EN
    issue("mult",       K_MULT, 5'd1, 5'd2, 5'd0, 0, 2'b00, 2'b00, 0);
    for (int i = 5; i >= 1; i--)
      issue($sformatf("mflo_stl%0d", i), K_MFLO, 5'd0, 5'd0, 5'd6, 1, 2'b00, 2'b00, 1);
    issue("mflo_go",    K_MFLO, 5'd0, 5'd0, 5'd6, 0, 2'b00, 2'b00, 0);
    issue("mult2",      K_MULT, 5'd1, 5'd2, 5'd0, 0, 2'b00, 2'b00, 0);
    issue("mflo2_stl",  K_MFLO, 5'd0, 5'd0, 5'd6, 1, 2'b00, 2'b00, 1);
    pulse_reset();
    issue("md_rst",     K_NOP,  5'd0, 5'd0, 5'd0, 0, 2'b00, 2'b00, 0);
`else
    issue("mult",       K_MULT, 5'd1, 5'd2, 5'd0, 0, 2'b00, 2'b00, 0);
    issue("mflo_free",  K_MFLO, 5'd0, 5'd0, 5'd6, 0, 2'b00, 2'b00, 0);
`endif

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
